// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and helpers for the stopwatch control slice.
// Holds the mode-FSM state encoding, the adjust-target encoding and a
// counter width helper used by the dividers and the debouncer.
package stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PAUSED = 2'd1,
      ADJUST = 2'd2
   } state_t;

   localparam logic SEL_MIN = 1'b0;
   localparam logic SEL_SEC = 1'b1;

   // Bits needed to hold the values 0..n-1 (never less than one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Pause-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on the accepted edge of the debounced level.
// Build option PAUSE_ON_RELEASE_EN moves the pulse to the 1->0 (release)
// edge; by default it fires on the 0->1 (press) edge.
module btn_debounce
   import stopwatch_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic sync1;
   logic sync2;
   logic stable;
   logic stable_d;
   logic edge_det;
   logic [CW-1:0] cnt;

   // Bring the raw asynchronous button into the clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has differed from the stable level for DEBOUNCE_CYCLES samples in a row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (sync2 != stable) begin
         if (cnt == CNT_LAST) begin
            cnt    <= '0;
            stable <= sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

`ifdef PAUSE_ON_RELEASE_EN
   assign edge_det = stable_d & ~stable;
`else
   assign edge_det = stable & ~stable_d;
`endif

   // Register the selected edge of the debounced level as a single-cycle press pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_d <= 1'b0;
         press    <= 1'b0;
      end else begin
         stable_d <= stable;
         press    <= edge_det;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and timing sequencer.
// Generates the 2 Hz / 1 Hz / display-refresh timebases, runs the
// RUN / PAUSED / ADJUST mode FSM and produces the increment, blink and
// digit-scan controls for the counter datapath and 7-segment mux.
// Build option PAUSE_ON_RELEASE_EN (handled in btn_debounce) makes the
// pause button act on release instead of press.
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int CLK_HZ          = 100000000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REFRESH_DIV     = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btnP,
   input  logic       sw_adj,
   input  logic       sw_sel,
   output logic       inc_pulse,
   output logic       adj_mode,
   output logic       adj_sel,
   output logic       paused,
   output logic       blink,
   output logic       tick_refresh,
   output logic [1:0] digit_sel
);

   localparam int HALF = CLK_HZ / 2;
   localparam int HW   = cnt_width(HALF);
   localparam int RW   = cnt_width(REFRESH_DIV);
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
   localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);

   logic          press;
   logic [HW-1:0] cnt_2hz;
   logic          tick_2hz;
   logic          tick_1hz;
   logic          phase_1hz;
   logic [RW-1:0] cnt_ref;
   state_t        state;
   state_t        state_next;
   logic          pf;
   logic          pf_next;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btnP),
      .press(press)
   );

   // Half-second timebase; every second wrap also yields the 1 Hz tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_2hz   <= '0;
         tick_2hz  <= 1'b0;
         tick_1hz  <= 1'b0;
         phase_1hz <= 1'b0;
      end else begin
         tick_2hz <= 1'b0;
         tick_1hz <= 1'b0;
         if (cnt_2hz == HALF_LAST) begin
            cnt_2hz   <= '0;
            tick_2hz  <= 1'b1;
            tick_1hz  <= phase_1hz;
            phase_1hz <= ~phase_1hz;
         end else begin
            cnt_2hz <= cnt_2hz + HW'(1);
         end
      end
   end

   // Display scan timebase and the anode index it steps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_ref      <= '0;
         tick_refresh <= 1'b0;
         digit_sel    <= 2'd0;
      end else begin
         tick_refresh <= 1'b0;
         if (cnt_ref == REF_LAST) begin
            cnt_ref      <= '0;
            tick_refresh <= 1'b1;
         end else begin
            cnt_ref <= cnt_ref + RW'(1);
         end
         if (tick_refresh) begin
            digit_sel <= digit_sel + 2'd1;
         end
      end
   end

   // Mode decision: the adjust switch wins over a press, and leaving ADJUST lands in the mode the hold flag says.
   always_comb begin
      pf_next    = pf ^ press;
      state_next = state;
      case (state)
         RUN: begin
            if (sw_adj) begin
               state_next = ADJUST;
            end else if (press) begin
               state_next = PAUSED;
            end
         end
         PAUSED: begin
            if (sw_adj) begin
               state_next = ADJUST;
            end else if (press) begin
               state_next = RUN;
            end
         end
         ADJUST: begin
            if (!sw_adj) begin
               state_next = pf_next ? PAUSED : RUN;
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   // Mode register and the hold flag that every press toggles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         pf    <= 1'b0;
      end else begin
         state <= state_next;
         pf    <= pf_next;
      end
   end

   // Registered datapath controls: increment strobe, adjust indicators and the blink mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inc_pulse <= 1'b0;
         adj_mode  <= 1'b0;
         adj_sel   <= SEL_MIN;
         blink     <= 1'b1;
      end else begin
         inc_pulse <= ((state == RUN) && tick_1hz) || ((state == ADJUST) && tick_2hz);
         adj_mode  <= (state_next == ADJUST);
         adj_sel   <= sw_sel ? SEL_SEC : SEL_MIN;
         if (state_next != ADJUST) begin
            blink <= 1'b1;
         end else if ((state == ADJUST) && tick_2hz) begin
            blink <= ~blink;
         end
      end
   end

   assign paused = pf;

endmodule
